// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit for the execute stage.
// Tracks the destinations of the instructions in EX, MEM and WB, registers
// the operand/store-value mux selects for the instruction entering execute,
// and holds decode for one cycle when an operand depends on a load in EX.
module fwd_hazard_unit #(
  parameter int RW    = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RW-1:0]    id_rs1,
  input  logic             id_rs1_used,
  input  logic [RW-1:0]    id_rs2,
  input  logic             id_rs2_used,
  input  logic [RW-1:0]    id_rst,
  input  logic             id_st_used,
  input  logic [RW-1:0]    id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             hold,
  output logic [1:0]       reg1_sel,
  output logic [1:0]       reg2_sel,
  output logic [1:0]       ST_reg_sel,
  output logic             stall_fd,
  output logic             bubble_ex,
  output logic [CNT_W-1:0] stall_count
);

  // One in-flight instruction as seen by the forwarding logic.
  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic          we;
    logic          load;
  } entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [1:0] SEL_REG = 2'b00;  // value read in decode
  localparam logic [1:0] SEL_MEM = 2'b01;  // mem_result
  localparam logic [1:0] SEL_WB  = 2'b10;  // wb_result

  localparam entry_t ENTRY_NONE = '{valid: 1'b0, rd: {RW{1'b0}}, we: 1'b0, load: 1'b0};

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // True when entry e produces register idx for a used operand; with
  // need_load set, only a load producer counts.
  function automatic logic entry_hit(
    input entry_t        e,
    input logic [RW-1:0] idx,
    input logic          used,
    input logic          need_load
  );
    return used & e.valid & e.we & (e.rd == idx) & (~need_load | e.load);
  endfunction

  // Source select for one operand. The EX producer will sit in MEM when the
  // consumer executes, the MEM producer in WB. A WB producer has already
  // written the register file (write-before-read), so the decode value is
  // correct for it.
  function automatic logic [1:0] fwd_sel(
    input entry_t        ex,
    input entry_t        mem,
    input entry_t        wb,
    input logic [RW-1:0] idx,
    input logic          used
  );
    logic [1:0] sel;
    if (entry_hit(ex, idx, used, 1'b0)) begin
      sel = SEL_MEM;
    end else if (entry_hit(mem, idx, used, 1'b0)) begin
      sel = SEL_WB;
    end else if (entry_hit(wb, idx, used, 1'b0)) begin
      sel = SEL_REG;
    end else begin
      sel = SEL_REG;
    end
    return sel;
  endfunction

  entry_t           ex_r;
  entry_t           mem_r;
  entry_t           wb_r;
  state_t           state_r;
  logic [1:0]       reg1_sel_r;
  logic [1:0]       reg2_sel_r;
  logic [1:0]       st_sel_r;
  logic [CNT_W-1:0] stall_count_r;

  entry_t     dec_entry_s;
  logic       load_hit_s;
  logic       stall_s;
  logic [1:0] reg1_next_s;
  logic [1:0] reg2_next_s;
  logic [1:0] st_next_s;

  // Decode-side view: next EX entry, next selects and load-use detection.
  always_comb begin
    dec_entry_s = '{valid: 1'b1, rd: id_rd, we: id_reg_write, load: id_is_load};
    reg1_next_s = fwd_sel(ex_r, mem_r, wb_r, id_rs1, id_rs1_used);
    reg2_next_s = fwd_sel(ex_r, mem_r, wb_r, id_rs2, id_rs2_used);
    st_next_s   = fwd_sel(ex_r, mem_r, wb_r, id_rst, id_st_used);
    load_hit_s  = entry_hit(ex_r, id_rs1, id_rs1_used, 1'b1) |
                  entry_hit(ex_r, id_rs2, id_rs2_used, 1'b1) |
                  entry_hit(ex_r, id_rst, id_st_used, 1'b1);
    // Flush kills the decode instruction, so it cannot stall; hold freezes
    // everything. The STALL state limits each hazard to one cycle.
    if ((state_r == RUN) && !flush && !hold) begin
      stall_s = load_hit_s;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Advance the EX/MEM/WB tracking entries and register the selects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_r       <= ENTRY_NONE;
      mem_r      <= ENTRY_NONE;
      wb_r       <= ENTRY_NONE;
      reg1_sel_r <= SEL_REG;
      reg2_sel_r <= SEL_REG;
      st_sel_r   <= SEL_REG;
    end else if (!hold) begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      if (flush || stall_s) begin
        ex_r       <= ENTRY_NONE;
        reg1_sel_r <= SEL_REG;
        reg2_sel_r <= SEL_REG;
        st_sel_r   <= SEL_REG;
      end else begin
        ex_r       <= dec_entry_s;
        reg1_sel_r <= reg1_next_s;
        reg2_sel_r <= reg2_next_s;
        st_sel_r   <= st_next_s;
      end
    end else begin
      ex_r       <= ex_r;
      mem_r      <= mem_r;
      wb_r       <= wb_r;
      reg1_sel_r <= reg1_sel_r;
      reg2_sel_r <= reg2_sel_r;
      st_sel_r   <= st_sel_r;
    end
  end

  // Stall sequencing: RUN detects hazards, STALL lets the held instruction go.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
    end else if (hold) begin
      state_r <= state_r;
    end else if (flush) begin
      state_r <= RUN;
    end else begin
      case (state_r)
        RUN:     state_r <= stall_s ? STALL : RUN;
        STALL:   state_r <= RUN;
        default: state_r <= RUN;
      endcase
    end
  end

  // Saturating count of inserted load-use bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_r <= CNT_ZERO;
    end else if (stall_s && (stall_count_r != CNT_MAX)) begin
      stall_count_r <= stall_count_r + CNT_ONE;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign reg1_sel    = reg1_sel_r;
  assign reg2_sel    = reg2_sel_r;
  assign ST_reg_sel  = st_sel_r;
  assign stall_fd    = stall_s;
  assign bubble_ex   = stall_s;
  assign stall_count = stall_count_r;

endmodule
